// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter and sequencer that serialises two requesters' read/write
// transactions onto a single-port register file and routes read data back.
module rf_port_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int RF_DEPTH   = 8,
  parameter int RF_WIDTH   = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  // requester A
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [RF_WIDTH-1:0]   a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [RF_WIDTH-1:0]   a_rdata,
  output logic                  a_err,
  // requester B
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [RF_WIDTH-1:0]   b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [RF_WIDTH-1:0]   b_rdata,
  output logic                  b_err,
  // register file
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic                  rf_write_enable,
  output logic                  rf_read_enable,
  output logic [RF_WIDTH-1:0]   rf_write_data,
  input  logic [RF_WIDTH-1:0]   rf_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;

  localparam int          CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [31:0] DEPTH_U = 32'(RF_DEPTH);
  localparam logic        OWNER_A = 1'b0;
  localparam logic        OWNER_B = 1'b1;

  state_e                state_q, state_d;
  logic                  last_owner_q, last_owner_d;  // also the in-flight owner
  logic                  we_q, we_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic                  a_err_q, a_err_d, b_err_q, b_err_d;
  logic [RF_WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
  logic                  rf_we_q, rf_we_d, rf_re_q, rf_re_d;
  logic [RF_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic                  busy_q, busy_d;

  logic                  pick_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RF_WIDTH-1:0]   sel_wdata;
  logic                  sel_legal;
  logic [RF_WIDTH-1:0]   rd_word;

  // B wins when it is alone, or when both ask and A owned the last slot.
  always_comb begin
    pick_b    = b_req && (!a_req || (last_owner_q == OWNER_A));
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_legal = (32'(sel_addr) < DEPTH_U);
  end

  // NOTE: every signal written below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    illegal_d    = illegal_q;
    cnt_d        = cnt_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    a_err_d      = 1'b0;
    b_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    rf_address_d = rf_address_q;
    rf_wdata_d   = rf_wdata_q;
    rf_we_d      = 1'b0;
    rf_re_d      = 1'b0;
    rd_word      = illegal_q ? '0 : rf_read_data;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d      = ISSUE;
          last_owner_d = pick_b;
          we_d         = sel_we;
          illegal_d    = !sel_legal;
          rf_address_d = sel_addr;
          rf_wdata_d   = sel_wdata;
          rf_we_d      = sel_we && sel_legal;
          rf_re_d      = !sel_we && sel_legal;
          a_gnt_d      = !pick_b;
          b_gnt_d      = pick_b;
          a_err_d      = !pick_b && sel_we && !sel_legal;
          b_err_d      = pick_b && sel_we && !sel_legal;
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end

      RDWAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (last_owner_q == OWNER_B) begin
            b_rdata_d  = rd_word;
            b_rvalid_d = 1'b1;
            b_err_d    = illegal_q;
          end else begin
            a_rdata_d  = rd_word;
            a_rvalid_d = 1'b1;
            a_err_d    = illegal_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_B;
      we_q         <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_q        <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      rf_address_q <= '0;
      rf_wdata_q   <= '0;
      rf_we_q      <= 1'b0;
      rf_re_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      illegal_q    <= illegal_d;
      cnt_q        <= cnt_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_err_q      <= a_err_d;
      b_err_q      <= b_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      rf_address_q <= rf_address_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_re_q      <= rf_re_d;
      busy_q       <= busy_d;
    end
  end

  assign a_gnt           = a_gnt_q;
  assign b_gnt           = b_gnt_q;
  assign a_rvalid        = a_rvalid_q;
  assign b_rvalid        = b_rvalid_q;
  assign a_err           = a_err_q;
  assign b_err           = b_err_q;
  assign a_rdata         = a_rdata_q;
  assign b_rdata         = b_rdata_q;
  assign rf_address      = rf_address_q;
  assign rf_write_data   = rf_wdata_q;
  assign rf_write_enable = rf_we_q;
  assign rf_read_enable  = rf_re_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter: directed transactions push expected
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_rf_port_arbiter;

  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int RDL   = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [W-1:0]  a_rdata, b_rdata;
  logic [AW-1:0] rf_address;
  logic          rf_write_enable, rf_read_enable, busy;
  logic [W-1:0]  rf_write_data, rf_read_data;

  always #5 CLK = ~CLK;

  rf_port_arbiter #(
    .ADDR_WIDTH(AW), .RF_DEPTH(DEPTH), .RF_WIDTH(W), .RD_LAT(RDL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .rf_address(rf_address), .rf_write_enable(rf_write_enable),
    .rf_read_enable(rf_read_enable), .rf_write_data(rf_write_data),
    .rf_read_data(rf_read_data), .busy(busy)
  );

  // Register file model: zero-initialised, read data valid RDL-1 edges after
  // the edge sampling rf_read_enable, held until the next read.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] pipe [RDL];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < RDL; i++) pipe[i] = '0;
  end
  always @(posedge CLK) begin
    if (rf_write_enable && rf_address < AW'(DEPTH)) mem[rf_address[2:0]] <= rf_write_data;
    if (rf_read_enable && rf_address < AW'(DEPTH)) pipe[0] <= mem[rf_address[2:0]];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign rf_read_data = pipe[RDL-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // kind: 0 = grant, 1 = read completion
  typedef struct packed { bit kind; bit side; bit err; logic [W-1:0] rdata; } ev_t;
  typedef struct packed { bit we; logic [AW-1:0] addr; logic [W-1:0] wdata; } rf_op_t;
  ev_t    exp_ev[$];
  rf_op_t exp_rf[$];

  function automatic void exp_gnt(input bit side, input bit err);
    ev_t e;
    e.kind = 1'b0; e.side = side; e.err = err; e.rdata = '0;
    exp_ev.push_back(e);
  endfunction

  function automatic void exp_rv(input bit side, input bit err, input logic [W-1:0] d);
    ev_t e;
    e.kind = 1'b1; e.side = side; e.err = err; e.rdata = d;
    exp_ev.push_back(e);
  endfunction

  function automatic void exp_op(input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    rf_op_t r;
    r.we = we; r.addr = a; r.wdata = d;
    exp_rf.push_back(r);
  endfunction

  // Monitor
  ev_t    mon_e;
  rf_op_t mon_r;
  bit     mon_side;
  bit     prev_busy = 1'b0;
  int     last_gnt_cyc = 0;
  always @(negedge CLK) begin
    if (a_gnt || b_gnt || a_rvalid || b_rvalid) begin
      check("one_event_per_cycle", 32'($countones({a_gnt, b_gnt, a_rvalid, b_rvalid})), 1);
      mon_side = b_gnt || b_rvalid;
      if (exp_ev.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        mon_e = exp_ev.pop_front();
        if (a_gnt || b_gnt) begin
          check("event_kind_gnt", 0, 32'(mon_e.kind));
          check("gnt_side", 32'(mon_side), 32'(mon_e.side));
          check("gnt_err", mon_side ? b_err : a_err, 32'(mon_e.err));
          check("busy_in_issue", busy, 1);
          check("busy_before_gnt", prev_busy, 0);
          last_gnt_cyc = cyc;
        end else begin
          check("event_kind_rvalid", 1, 32'(mon_e.kind));
          check("rvalid_side", 32'(mon_side), 32'(mon_e.side));
          check("rvalid_rdata", mon_side ? b_rdata : a_rdata, mon_e.rdata);
          check("rvalid_err", mon_side ? b_err : a_err, 32'(mon_e.err));
          check("busy_after_read", busy, 0);
          check("gnt_to_rvalid_latency", cyc - last_gnt_cyc, RDL + 1);
        end
      end
    end
    if (rf_write_enable || rf_read_enable) begin
      check("rf_enable_exclusive", rf_write_enable & rf_read_enable, 0);
      check("rf_enable_with_gnt", a_gnt | b_gnt, 1);
      if (exp_rf.size() == 0) begin
        check("unexpected_rf_op", 1, 0);
      end else begin
        mon_r = exp_rf.pop_front();
        check("rf_op_we", rf_write_enable, 32'(mon_r.we));
        check("rf_op_addr", rf_address, mon_r.addr);
        if (mon_r.we) check("rf_op_wdata", rf_write_data, mon_r.wdata);
      end
    end
    prev_busy = busy;
  end

  // Present one transaction, hold it until the grant is seen, release at the next edge.
  task automatic drive(input bit side, input bit we, input logic [AW-1:0] addr,
                       input logic [W-1:0] wdata, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    if (side) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (side ? b_gnt : a_gnt) begin got = 1'b1; gcyc = cyc; break; end
    end
    if (!got) check(side ? "b_gnt_timeout" : "a_gnt_timeout", 0, 1);
    @(posedge CLK); #1;
    if (side) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic wait_gnt(input bit side);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (side ? b_gnt : a_gnt) begin got = 1'b1; break; end
    end
    if (!got) check("wait_gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80 && (exp_ev.size() != 0 || exp_rf.size() != 0); i++) @(posedge CLK);
    check({tag, "_drained"}, 32'(exp_ev.size() + exp_rf.size()), 0);
    exp_ev.delete();
    exp_rf.delete();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pulses"}, {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err}, 0);
    check({tag, "_rf_en"}, {rf_write_enable, rf_read_enable}, 0);
    check({tag, "_rf_address"}, rf_address, 0);
    check({tag, "_rf_wdata"}, rf_write_data, 0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_b_rdata"}, b_rdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, g1, g2, gb, t0, fall;
    int ga [4];

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Back-to-back writes from A: grants two cycles apart.
    exp_gnt(0, 0); exp_op(1, 4'd2, 16'd22);
    exp_gnt(0, 0); exp_op(1, 4'd3, 16'd23);
    drive(0, 1, 4'd2, 16'd22, g0);
    drive(0, 1, 4'd3, 16'd23, g1);
    check("t1_gnt_spacing", g1 - g0, 2);
    wait_idle("t1");

    // A reads 2, B reads 3 one cycle later and waits its turn.
    exp_gnt(0, 0); exp_op(0, 4'd2, '0); exp_rv(0, 0, 16'd22);
    exp_gnt(1, 0); exp_op(0, 4'd3, '0); exp_rv(1, 0, 16'd23);
    t0 = cyc;
    fork
      drive(0, 0, 4'd2, '0, g0);
      begin @(posedge CLK); #1; drive(1, 0, 4'd3, '0, g1); end
    join
    check("t2_gnt_latency", g0 - t0, 1);
    wait_idle("t2");
    check("t2_a_rdata_hold", a_rdata, 16'd22);
    check("t2_b_rdata", b_rdata, 16'd23);

    // Reset, then contended writes alternate starting with A.
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_gnt(0, 0); exp_op(1, 4'd5, 16'h00A5);
      exp_gnt(1, 0); exp_op(1, 4'd6, 16'h00B6);
    end
    fork
      for (int k = 0; k < 4; k++) drive(0, 1, 4'd5, 16'h00A5, g0);
      for (int k = 0; k < 4; k++) drive(1, 1, 4'd6, 16'h00B6, g1);
    join
    wait_idle("t3w");
    exp_gnt(0, 0); exp_op(0, 4'd5, '0); exp_rv(0, 0, 16'h00A5);
    exp_gnt(1, 0); exp_op(0, 4'd6, '0); exp_rv(1, 0, 16'h00B6);
    fork
      drive(0, 0, 4'd5, '0, g0);
      drive(1, 0, 4'd6, '0, g1);
    join
    wait_idle("t3r");

    // Top legal entry, overwrite of entry 0, illegal read and write.
    exp_gnt(1, 0); exp_op(0, 4'd7, '0); exp_rv(1, 0, 16'h0000);
    exp_gnt(0, 0); exp_op(1, 4'd0, 16'hFFFF);
    exp_gnt(1, 0); exp_op(0, 4'd0, '0); exp_rv(1, 0, 16'hFFFF);
    exp_gnt(1, 0); exp_rv(1, 1, 16'h0000);
    exp_gnt(0, 1);
    drive(1, 0, 4'd7, '0, g0);
    drive(0, 1, 4'd0, 16'hFFFF, g0);
    drive(1, 0, 4'd0, '0, g0);
    drive(1, 0, 4'd9, '0, g0);
    drive(0, 1, 4'd12, 16'h1234, g0);
    wait_idle("t4");

    // Reset while a read waits: no completion, held request re-granted.
    exp_gnt(0, 0); exp_op(0, 4'd2, '0);
    exp_gnt(0, 0); exp_op(1, 4'd4, 16'h0044);
    fork
      begin
        drive(0, 0, 4'd2, '0, g0);
        drive(0, 1, 4'd4, 16'h0044, g2);
      end
      begin
        wait_gnt(0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        fall = cyc;
        @(negedge CLK);
        check_reset("t5_mid_rst");
      end
    join
    check("t5_regrant_latency", g2 - fall, 1);
    wait_idle("t5");

    // A streams writes; B joins after the first grant and wins the next slot.
    exp_gnt(0, 0); exp_op(1, 4'd1, 16'h0011);
    exp_gnt(1, 0); exp_op(0, 4'd1, '0); exp_rv(1, 0, 16'h0011);
    exp_gnt(0, 0); exp_op(1, 4'd1, 16'h0022);
    exp_gnt(0, 0); exp_op(1, 4'd1, 16'h0033);
    exp_gnt(0, 0); exp_op(1, 4'd1, 16'h0044);
    fork
      for (int k = 0; k < 4; k++) drive(0, 1, 4'd1, 16'(16'h0011 * (k + 1)), ga[k]);
      begin
        wait_gnt(0);
        @(posedge CLK); #1;
        drive(1, 0, 4'd1, '0, gb);
      end
    join
    check("t6_b_next_arb", gb - ga[0], 2);
    check("t6_a_resume", ga[1] - gb, RDL + 2);
    check("t6_a_spacing", ga[3] - ga[2], 2);
    wait_idle("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
